// File: rtl/bus_mux_reg.sv
// Registered priority bus multiplexer for the shared CPU bus.
// Source 0 has the highest priority. Each source has a run-time override
// entry that can replace its data on the bus. Simultaneous enables are
// reported as contention through a pulse, a sticky flag and a saturating
// counter. The old tri-state bus is replaced entirely by this mux; nothing
// here ever drives 'z'.
module bus_mux_reg #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 24,
    parameter bit HOLD    = 1'b1,
    parameter int CNTW    = 8,
    parameter int SELW    = $clog2(NUM_SRC)
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_en,
    input  logic                     ovr_wr,
    input  logic [SELW-1:0]          ovr_idx,
    input  logic                     ovr_set,
    input  logic [WIDTH-1:0]         ovr_val,
    input  logic                     sticky_clr,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    output logic [SELW-1:0]          bus_owner,
    output logic                     conflict,
    output logic                     conflict_sticky,
    output logic [CNTW-1:0]          conflict_count
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [WIDTH-1:0] bus_q,      bus_d;
    logic             valid_q,    valid_d;
    logic [SELW-1:0]  owner_q,    owner_d;
    logic             conflict_q, conflict_d;
    logic             sticky_q,   sticky_d;
    logic [CNTW-1:0]  count_q,    count_d;

    logic             ovr_en_q  [NUM_SRC];
    logic             ovr_en_d  [NUM_SRC];
    logic [WIDTH-1:0] ovr_val_q [NUM_SRC];
    logic [WIDTH-1:0] ovr_val_d [NUM_SRC];

    logic             win_valid;
    logic [SELW-1:0]  win_idx;
    logic [WIDTH-1:0] win_data;
    logic             multi_en;

    // Priority select: scanning from the top down lets the lowest enabled index win.
    // The table is read from the current registers, so a write on this edge
    // only affects selections from the next edge onward.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_en[i]) begin
                win_valid = 1'b1;
                win_idx   = SELW'(i);
                win_data  = ovr_en_q[i] ? ovr_val_q[i] : src_data[i*WIDTH +: WIDTH];
            end
        end
        multi_en = ($countones(src_en) >= 2);
    end

    // Override table next state. An index outside the source range matches no entry,
    // so the write is ignored.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            ovr_en_d[i]  = ovr_en_q[i];
            ovr_val_d[i] = ovr_val_q[i];
            if (ovr_wr && (ovr_idx == SELW'(i))) begin
                ovr_en_d[i]  = ovr_set;
                ovr_val_d[i] = ovr_val;
            end
        end
    end

    // Bus data, owner and contention next state.
    // When sticky_clr and a conflict occur together, the clear is applied
    // first and the new event is then counted.
    always_comb begin
        valid_d    = win_valid;
        owner_d    = win_valid ? win_idx : owner_q;
        bus_d      = bus_q;
        if (win_valid) begin
            bus_d = win_data;
        end else if (!HOLD) begin
            bus_d = '0;
        end

        conflict_d = multi_en;
        if (sticky_clr) begin
            sticky_d = multi_en;
            count_d  = multi_en ? CNTW'(1) : '0;
        end else begin
            sticky_d = sticky_q | multi_en;
            count_d  = (multi_en && (count_q != CNT_MAX)) ? count_q + CNTW'(1) : count_q;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            bus_q      <= '0;
            valid_q    <= 1'b0;
            owner_q    <= '0;
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
            ovr_en_q   <= '{default: 1'b0};
            ovr_val_q  <= '{default: '0};
        end else begin
            bus_q      <= bus_d;
            valid_q    <= valid_d;
            owner_q    <= owner_d;
            conflict_q <= conflict_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
            ovr_en_q   <= ovr_en_d;
            ovr_val_q  <= ovr_val_d;
        end
    end

    assign bus_out         = bus_q;
    assign bus_valid       = valid_q;
    assign bus_owner       = owner_q;
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;
    assign conflict_count  = count_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed and random bench for bus_mux_reg. Three instances share the same
// stimulus: default parameters (HOLD=1), HOLD=0, and CNTW=2.
module tb_bus_mux_reg;

    localparam int W  = 32;
    localparam int NS = 24;
    localparam int SW = 5;

    logic            clock = 1'b0;
    logic            clear;
    logic [NS*W-1:0] src_data;
    logic [NS-1:0]   src_en;
    logic            ovr_wr;
    logic [SW-1:0]   ovr_idx;
    logic            ovr_set;
    logic [W-1:0]    ovr_val;
    logic            sticky_clr;

    logic [W-1:0]  h1_bus,   h0_bus,   c2_bus;
    logic          h1_vld,   h0_vld,   c2_vld;
    logic [SW-1:0] h1_own,   h0_own,   c2_own;
    logic          h1_cf,    h0_cf,    c2_cf;
    logic          h1_st,    h0_st,    c2_st;
    logic [7:0]    h1_cnt,   h0_cnt;
    logic [1:0]    c2_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    bus_mux_reg u_h1 (
        .clock(clock), .clear(clear), .src_data(src_data), .src_en(src_en),
        .ovr_wr(ovr_wr), .ovr_idx(ovr_idx), .ovr_set(ovr_set), .ovr_val(ovr_val),
        .sticky_clr(sticky_clr), .bus_out(h1_bus), .bus_valid(h1_vld),
        .bus_owner(h1_own), .conflict(h1_cf), .conflict_sticky(h1_st),
        .conflict_count(h1_cnt)
    );

    bus_mux_reg #(.HOLD(1'b0)) u_h0 (
        .clock(clock), .clear(clear), .src_data(src_data), .src_en(src_en),
        .ovr_wr(ovr_wr), .ovr_idx(ovr_idx), .ovr_set(ovr_set), .ovr_val(ovr_val),
        .sticky_clr(sticky_clr), .bus_out(h0_bus), .bus_valid(h0_vld),
        .bus_owner(h0_own), .conflict(h0_cf), .conflict_sticky(h0_st),
        .conflict_count(h0_cnt)
    );

    bus_mux_reg #(.CNTW(2)) u_c2 (
        .clock(clock), .clear(clear), .src_data(src_data), .src_en(src_en),
        .ovr_wr(ovr_wr), .ovr_idx(ovr_idx), .ovr_set(ovr_set), .ovr_val(ovr_val),
        .sticky_clr(sticky_clr), .bus_out(c2_bus), .bus_valid(c2_vld),
        .bus_owner(c2_own), .conflict(c2_cf), .conflict_sticky(c2_st),
        .conflict_count(c2_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_src(input int i, input logic [W-1:0] v);
        src_data[i*W +: W] = v;
    endtask

    task automatic ovr_write(input int idx, input logic set, input logic [W-1:0] val);
        ovr_wr  = 1'b1;
        ovr_idx = SW'(idx);
        ovr_set = set;
        ovr_val = val;
    endtask

    // Reference state for the random phase.
    logic          m_en  [NS];
    logic [W-1:0]  m_val [NS];
    logic [W-1:0]  e_bus1, e_bus0;
    logic [SW-1:0] e_own;
    logic          e_vld, e_cf;

    initial begin
        clear      = 1'b0;
        src_data   = '0;
        src_en     = '0;
        ovr_wr     = 1'b0;
        ovr_idx    = '0;
        ovr_set    = 1'b0;
        ovr_val    = '0;
        sticky_clr = 1'b0;

        #2;
        check("rst_bus",   h1_bus, 0);
        check("rst_valid", h1_vld, 0);
        check("rst_count", h1_cnt, 0);
        #21 clear = 1'b1;

        tick();
        check("idle_bus",   h1_bus, 0);
        check("idle_valid", h1_vld, 0);
        check("idle_count", h1_cnt, 0);

        // PC drives the bus, then idle behaviour for both HOLD settings.
        set_src(21, 32'h0000_0010);
        src_en = NS'(1) << 21;
        tick();
        check("pc_bus",   h1_bus, 32'h10);
        check("pc_valid", h1_vld, 1);
        check("pc_owner", h1_own, 21);
        check("pc_conf",  h1_cf,  0);
        src_en = '0;
        tick();
        check("hold1_bus",   h1_bus, 32'h10);
        check("hold1_valid", h1_vld, 0);
        check("hold1_owner", h1_own, 21);
        check("hold0_bus",   h0_bus, 0);
        check("hold0_valid", h0_vld, 0);

        // R2 and R5 both enabled.
        set_src(2, 32'hAAAA);
        set_src(5, 32'h5555);
        src_en = (NS'(1) << 2) | (NS'(1) << 5);
        tick();
        check("cf_bus",    h1_bus, 32'hAAAA);
        check("cf_owner",  h1_own, 2);
        check("cf_pulse",  h1_cf,  1);
        check("cf_sticky", h1_st,  1);
        check("cf_count",  h1_cnt, 1);
        src_en = '0;
        tick();
        check("cf_pulse_end",  h1_cf, 0);
        check("cf_sticky_hold", h1_st, 1);
        check("cf_count_hold", h1_cnt, 1);

        // Override: no write-through, then disable, then out-of-range write.
        set_src(2, 32'h1234);
        src_en = NS'(1) << 2;
        ovr_write(2, 1'b1, 32'h78);
        tick();
        check("ovr_same_edge", h1_bus, 32'h1234);
        ovr_wr = 1'b0;
        tick();
        check("ovr_active", h1_bus, 32'h78);
        ovr_write(2, 1'b0, 32'h0);
        tick();
        check("ovr_off_old", h1_bus, 32'h78);
        ovr_wr = 1'b0;
        tick();
        check("ovr_off_new", h1_bus, 32'h1234);
        ovr_write(30, 1'b1, 32'hDEAD);
        tick();
        ovr_wr = 1'b0;
        tick();
        check("ovr_oob_r2", h1_bus, 32'h1234);
        set_src(23, 32'h2323);
        src_en = NS'(1) << 23;
        tick();
        check("ovr_oob_r23", h1_bus, 32'h2323);

        // Saturation with a 2-bit counter.
        src_en     = '0;
        sticky_clr = 1'b1;
        tick();
        check("clr_c2_count", c2_cnt, 0);
        check("clr_c2_sticky", c2_st, 0);
        sticky_clr = 1'b0;
        src_en = NS'(3);
        begin
            logic [1:0] sat_exp [5];
            sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            for (int k = 0; k < 5; k++) begin
                tick();
                check($sformatf("sat_c2_%0d", k), c2_cnt, sat_exp[k]);
                check($sformatf("cnt_h1_%0d", k), h1_cnt, k + 1);
            end
        end
        sticky_clr = 1'b1;
        tick();
        check("clr_cf_count",  c2_cnt, 1);
        check("clr_cf_sticky", c2_st,  1);
        src_en = '0;
        tick();
        check("clr_only_count",  c2_cnt, 0);
        check("clr_only_sticky", c2_st,  0);
        sticky_clr = 1'b0;

        // Build some state, then assert reset between edges.
        set_src(3, 32'h33);
        set_src(4, 32'h44);
        src_en = (NS'(1) << 3) | (NS'(1) << 4);
        ovr_write(7, 1'b1, 32'h77);
        tick();
        ovr_wr = 1'b0;
        check("pre_rst_bus", h1_bus, 32'h33);
        check("pre_rst_sticky", h1_st, 1);
        #2 clear = 1'b0;
        #1;
        check("mid_rst_bus",    h1_bus, 0);
        check("mid_rst_valid",  h1_vld, 0);
        check("mid_rst_owner",  h1_own, 0);
        check("mid_rst_conf",   h1_cf,  0);
        check("mid_rst_sticky", h1_st,  0);
        check("mid_rst_count",  h1_cnt, 0);
        src_en = NS'(1) << 7;
        set_src(7, 32'h0707);
        #3 clear = 1'b1;
        tick();
        check("rst_ovr_cleared", h1_bus, 32'h0707);
        check("rst_ovr_owner",   h1_own, 7);

        // Random regression against a priority model with one-cycle latency.
        for (int i = 0; i < NS; i++) begin
            m_en[i]  = 1'b0;
            m_val[i] = '0;
        end
        e_bus1 = h1_bus;
        e_bus0 = h0_bus;
        e_own  = 7;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NS; i++) set_src(i, $urandom);
            src_en = NS'($urandom & $urandom & $urandom);
            ovr_wr  = ($urandom_range(0, 3) == 0);
            ovr_idx = SW'($urandom_range(0, 31));
            ovr_set = $urandom_range(0, 1) == 1;
            ovr_val = $urandom;

            e_vld = 1'b0;
            for (int i = NS - 1; i >= 0; i--) begin
                if (src_en[i]) begin
                    e_vld = 1'b1;
                    e_own = SW'(i);
                end
            end
            if (e_vld) begin
                e_bus1 = m_en[e_own] ? m_val[e_own] : src_data[int'(e_own)*W +: W];
                e_bus0 = e_bus1;
            end else begin
                e_bus0 = '0;
            end
            e_cf = ($countones(src_en) > 1);
            if (ovr_wr && (int'(ovr_idx) < NS)) begin
                m_en[ovr_idx]  = ovr_set;
                m_val[ovr_idx] = ovr_val;
            end

            tick();
            check("rnd_bus_h1", h1_bus, e_bus1);
            check("rnd_bus_h0", h0_bus, e_bus0);
            check("rnd_owner",  h1_own, e_own);
            check("rnd_valid",  h1_vld, e_vld);
            check("rnd_conf",   h1_cf,  e_cf);
            if (failures > 50) break;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered successor of the datapath's priority bus multiplexer; drives the shared 32-bit CPU bus from NUM_SRC sources (R0–R15, MDR, HI, LO, Zhigh, Zlow, PC, InPort, C by default).
- Adds a registered output, an owner index and valid flag, and bus-contention detection with a sticky flag and a saturating counter.
- Adds a run-time per-source override table. Test benches use it to force a fixed value onto the bus for a chosen source, without editing RTL.

Parameters:
- WIDTH, 32, bus data width in bits.
- NUM_SRC, 24, number of bus sources; index 0 has the highest priority.
- HOLD, 1, idle behaviour: 1 = bus_out keeps its last value when no source is enabled; 0 = bus_out is driven to zero.
- CNTW, 8, width of the conflict counter.
- SELW, $clog2(NUM_SRC), derived width of the source index. Not overridden.

Ports:
- clock  input  1  system clock, rising-edge.
- clear  input  1  asynchronous, active-low reset.
- src_data  input  NUM_SRC*WIDTH  source data, flattened; source i occupies bits [i*WIDTH +: WIDTH].
- src_en  input  NUM_SRC  per-source bus-drive enables (the xxout signals).
- ovr_wr  input  1  write strobe for the override table.
- ovr_idx  input  SELW  override table entry to write.
- ovr_set  input  1  value written to the entry's enable bit: 1 = override on, 0 = override off.
- ovr_val  input  WIDTH  override value written to the entry.
- sticky_clr  input  1  clears conflict_sticky and conflict_count.
- bus_out  output  WIDTH  registered bus value.
- bus_valid  output  1  a source was selected in the previous cycle.
- bus_owner  output  SELW  index of the winning source in the previous cycle.
- conflict  output  1  one-cycle pulse: two or more enables were asserted in the previous cycle.
- conflict_sticky  output  1  latched conflict indicator.
- conflict_count  output  CNTW  number of conflict cycles, saturating.

Behaviour:
- Reset (clear=0, asynchronous):
  - bus_out=0, bus_valid=0, bus_owner=0, conflict=0, conflict_sticky=0, conflict_count=0.
  - All override enables=0 and all override values=0.
  - Reset takes effect immediately, including mid-operation; the first update after release happens on the first rising edge with clear=1.
- Selection (combinational): winner = lowest index i with src_en[i]=1.
- Latency: all outputs are registered. src_en/src_data sampled at edge k appear on the outputs after edge k.
- Data path, per edge:
  - If a winner exists: bus_valid=1, bus_owner=winner.
  - bus_out = the winner's override value if its override enable is 1, otherwise src_data[winner].
  - If no source is enabled: bus_valid=0 and bus_owner holds its previous value.
  - With no source enabled, bus_out holds its value if HOLD=1 and is loaded with 0 if HOLD=0.
- Override table:
  - Written on an edge with ovr_wr=1: entry[ovr_idx] enable <= ovr_set, value <= ovr_val.
  - No write-through bypass. A write at edge k affects selections sampled from edge k+1 onward; the selection sampled at edge k uses the old entry.
  - Writes with ovr_idx >= NUM_SRC are ignored.
  - Writing ovr_set=0 disables the override. The stored value is also overwritten with ovr_val.
- Conflict detection:
  - conflict = 1 on the edge after a cycle in which popcount(src_en) >= 2; otherwise 0.
  - Data still follows the priority rule during a conflict.
  - conflict_sticky is set by conflict and cleared only by sticky_clr or reset.
  - conflict_count increments on each conflict cycle and saturates at 2^CNTW-1; there is no wrap-around.
- sticky_clr and a conflict in the same cycle:
  - conflict_sticky=1 and conflict_count=1.
  - The clear applies first, then the new event is counted.
- sticky_clr with no conflict: conflict_sticky=0 and conflict_count=0 on the next edge.
- Unknown or undriven inputs are never propagated by design intent. The tri-state bus is replaced by the registered mux; no 'z' is driven.

Test Plan:
- Reset, then src_en=0 -> after the first edge: bus_out=0, bus_valid=0, conflict_count=0. Assert clear=0 mid-run -> all outputs become 0 immediately, without waiting for an edge.
- src_en[21] (PC) set with PC data 0x0000_0010, one cycle -> next edge: bus_out=0x10, bus_valid=1, bus_owner=21. Then src_en=0 -> HOLD=1 gives bus_out=0x10 with bus_valid=0; repeat with HOLD=0 -> bus_out=0.
- src_en[2] and src_en[5] set with R2=0xAAAA, R5=0x5555 -> bus_out=0xAAAA, bus_owner=2, conflict pulses one cycle, conflict_sticky=1, conflict_count=1.
- Override:
  - Write ovr_idx=2, ovr_set=1, ovr_val=0x78 while src_en[2]=1 and R2 data=0x1234 in the same cycle -> bus_out=0x1234 on that edge, 0x78 on the next.
  - Write ovr_set=0 -> 0x1234 returns.
  - Write ovr_idx=30 -> no entry changes.
- CNTW=2, five consecutive conflict cycles -> conflict_count reads 1, 2, 3, 3, 3. Then sticky_clr together with a conflict -> count=1, sticky=1. Then sticky_clr alone -> count=0, sticky=0.
- Random regression, 10k cycles: bus_out and bus_owner match a priority reference model with 1-cycle latency, including override writes and random enables.
